crc_frame_engine: RTL and testbench

//  Parametrised serial CRC generator for framed bit streams; successor to the fixed 8-bit serial CRC.

---
 rtl/crc_frame_engine_if.sv | 45 ++++
 rtl/crc_frame_engine.sv | 147 ++++++++++++++
 tb/tb_crc_frame_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_engine_if.sv
// crc_frame_engine_if
// Frame control, serial data-in and serial CRC-out handshakes of crc_frame_engine.
// CRC_PAR_OUT_EN adds the parallel CRC_WORD / CRC_WORD_VLD result pair (and the
// CRC_WD parameter that sizes it); without it those signals do not exist.
interface crc_frame_engine_if #(
  parameter int LEN_WD = 16
`ifdef CRC_PAR_OUT_EN
  , parameter int CRC_WD = 8
`endif
);
  logic              START;
  logic [LEN_WD-1:0] FRAME_BITS;
  logic              DATA;
  logic              DATA_VALID;
  logic              IN_READY;
  logic              CRC_OUT;
  logic              CRC_VALID;
  logic              OUT_READY;
  logic              BUSY;
  logic              DONE;
`ifdef CRC_PAR_OUT_EN
  logic [CRC_WD-1:0] CRC_WORD;
  logic              CRC_WORD_VLD;

  modport master (
    output START, FRAME_BITS, DATA, DATA_VALID, OUT_READY,
    input  IN_READY, CRC_OUT, CRC_VALID, BUSY, DONE, CRC_WORD, CRC_WORD_VLD
  );

  modport slave (
    input  START, FRAME_BITS, DATA, DATA_VALID, OUT_READY,
    output IN_READY, CRC_OUT, CRC_VALID, BUSY, DONE, CRC_WORD, CRC_WORD_VLD
  );
`else
  modport master (
    output START, FRAME_BITS, DATA, DATA_VALID, OUT_READY,
    input  IN_READY, CRC_OUT, CRC_VALID, BUSY, DONE
  );

  modport slave (
    input  START, FRAME_BITS, DATA, DATA_VALID, OUT_READY,
    output IN_READY, CRC_OUT, CRC_VALID, BUSY, DONE
  );
`endif
endinterface

// File: rtl/crc_frame_engine.sv
// crc_frame_engine
// Parametrised serial CRC generator for framed bit streams on the TX path.
// Data bits enter MSB-first under DATA_VALID/IN_READY; the CRC leaves MSB-first
// under CRC_VALID/OUT_READY. Optional feature macro: CRC_PAR_OUT_EN (parallel
// CRC_WORD result plus a one-cycle CRC_WORD_VLD strobe).
module crc_frame_engine #(
  parameter int                CRC_WD  = 8,
  parameter logic [CRC_WD-1:0] POLY    = 'h07,
  parameter logic [CRC_WD-1:0] SEED    = '0,
  parameter logic [CRC_WD-1:0] XOR_OUT = '0,
  parameter int                LEN_WD  = 16
) (
  input logic               CLK,
  input logic               RST,
  crc_frame_engine_if.slave bus_io
);

  localparam int OCNT_WD = $clog2(CRC_WD + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    SHIFT_OUT = 2'd2
  } engineState_e;

  engineState_e       state_q;
  logic [CRC_WD-1:0]  lfsr_q;
  logic [CRC_WD-1:0]  lfsr_d;
  logic [LEN_WD-1:0]  cnt_q;
  logic [CRC_WD-1:0]  shiftReg_q;
  logic [OCNT_WD-1:0] outCnt_q;
  logic               inReady_q;
  logic               crcValid_q;
  logic               busy_q;
  logic               done_q;
  logic               feedback;
`ifdef CRC_PAR_OUT_EN
  logic [CRC_WD-1:0]  crcWord_q;
  logic               crcWordVld_q;
`endif

  // LFSR value after absorbing the bit currently offered on DATA
  always_comb begin
    feedback = lfsr_q[CRC_WD-1] ^ bus_io.DATA;
    lfsr_d   = {lfsr_q[CRC_WD-2:0], 1'b0} ^ (feedback ? POLY : '0);
  end

  // Frame sequencer: load on START, absorb data, shift the CRC out, pulse DONE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      cnt_q        <= '0;
      shiftReg_q   <= '0;
      outCnt_q     <= '0;
      inReady_q    <= 1'b0;
      crcValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CRC_PAR_OUT_EN
      crcWord_q    <= '0;
      crcWordVld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CRC_PAR_OUT_EN
      crcWordVld_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // The DONE cycle still belongs to the previous frame, so START is not honoured there
          if (bus_io.START && !done_q) begin
            lfsr_q <= SEED;
            cnt_q  <= bus_io.FRAME_BITS;
            busy_q <= 1'b1;
`ifdef CRC_PAR_OUT_EN
            crcWord_q <= '0;
`endif
            if (bus_io.FRAME_BITS == '0) begin
              state_q    <= SHIFT_OUT;
              shiftReg_q <= SEED ^ XOR_OUT;
              outCnt_q   <= OCNT_WD'(CRC_WD);
              crcValid_q <= 1'b1;
`ifdef CRC_PAR_OUT_EN
              crcWord_q    <= SEED ^ XOR_OUT;
              crcWordVld_q <= 1'b1;
`endif
            end else begin
              state_q   <= SHIFT_IN;
              inReady_q <= 1'b1;
            end
          end
        end

        SHIFT_IN: begin
          if (bus_io.DATA_VALID && inReady_q) begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_q - LEN_WD'(1);
            if (cnt_q == LEN_WD'(1)) begin
              state_q    <= SHIFT_OUT;
              inReady_q  <= 1'b0;
              shiftReg_q <= lfsr_d ^ XOR_OUT;
              outCnt_q   <= OCNT_WD'(CRC_WD);
              crcValid_q <= 1'b1;
`ifdef CRC_PAR_OUT_EN
              crcWord_q    <= lfsr_d ^ XOR_OUT;
              crcWordVld_q <= 1'b1;
`endif
            end
          end
        end

        SHIFT_OUT: begin
          if (crcValid_q && bus_io.OUT_READY) begin
            shiftReg_q <= {shiftReg_q[CRC_WD-2:0], 1'b0};
            outCnt_q   <= outCnt_q - OCNT_WD'(1);
            if (outCnt_q == OCNT_WD'(1)) begin
              state_q    <= IDLE;
              crcValid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              lfsr_q     <= SEED;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b0;
          crcValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.IN_READY  = inReady_q;
  assign bus_io.CRC_OUT   = shiftReg_q[CRC_WD-1];
  assign bus_io.CRC_VALID = crcValid_q;
  assign bus_io.BUSY      = busy_q;
  assign bus_io.DONE      = done_q;
`ifdef CRC_PAR_OUT_EN
  assign bus_io.CRC_WORD     = crcWord_q;
  assign bus_io.CRC_WORD_VLD = crcWordVld_q;
`endif

endmodule

// File: tb/tb_crc_frame_engine.sv
// tb_crc_frame_engine
// Three engines share one stimulus stream: CRC-8 (poly 07, seed 00), CRC-16 CCITT
// (poly 1021, seed FFFF) and CRC-8 with seed A5 / final XOR FF. Expected CRCs come
// from a polynomial long-division model; known check values are compared as constants.
`timescale 1ns/1ps
module tb_crc_frame_engine;

  localparam int NDUT   = 3;
  localparam int LEN_WD = 16;

  int unsigned cfgWd   [NDUT] = '{8, 16, 8};
  logic [31:0] cfgPoly [NDUT] = '{32'h07, 32'h1021, 32'h07};
  logic [31:0] cfgSeed [NDUT] = '{32'h00, 32'hFFFF, 32'hA5};
  logic [31:0] cfgXor  [NDUT] = '{32'h00, 32'h0000, 32'hFF};

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic start = 1'b0;
  logic [LEN_WD-1:0] frameBits = '0;
  logic data = 1'b0;
  logic dataValid = 1'b0;
  logic outReady = 1'b0;

  logic [NDUT-1:0] inReady;
  logic [NDUT-1:0] crcOut;
  logic [NDUT-1:0] crcValid;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;
`ifdef CRC_PAR_OUT_EN
  logic [NDUT-1:0][31:0] crcWord;
  logic [NDUT-1:0]       crcWordVld;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] lastCrc [NDUT];
  bit checkString[$];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int WD = (g == 1) ? 16 : 8;
    localparam logic [WD-1:0] P = (g == 1) ? WD'(32'h1021) : WD'(32'h07);
    localparam logic [WD-1:0] S = (g == 1) ? WD'(32'hFFFF) : ((g == 2) ? WD'(32'hA5) : WD'(32'h0));
    localparam logic [WD-1:0] X = (g == 2) ? WD'(32'hFF) : WD'(32'h0);

    crc_frame_engine_if #(
      .LEN_WD(LEN_WD)
`ifdef CRC_PAR_OUT_EN
      , .CRC_WD(WD)
`endif
    ) bus ();

    assign bus.START      = start;
    assign bus.FRAME_BITS = frameBits;
    assign bus.DATA       = data;
    assign bus.DATA_VALID = dataValid;
    assign bus.OUT_READY  = outReady;
    assign inReady[g]     = bus.IN_READY;
    assign crcOut[g]      = bus.CRC_OUT;
    assign crcValid[g]    = bus.CRC_VALID;
    assign busy[g]        = bus.BUSY;
    assign done[g]        = bus.DONE;
`ifdef CRC_PAR_OUT_EN
    assign crcWord[g]     = 32'(bus.CRC_WORD);
    assign crcWordVld[g]  = bus.CRC_WORD_VLD;
`endif

    crc_frame_engine #(
      .CRC_WD(WD), .POLY(P), .SEED(S), .XOR_OUT(X), .LEN_WD(LEN_WD)
    ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus_io(bus.slave)
    );
  end

  // CRC as the remainder of (M(x)*x^w + SEED(x)*x^n) mod G(x), then final XOR
  function automatic logic [31:0] refCrc(input int w, input logic [31:0] poly,
                                         input logic [31:0] seed, input logic [31:0] xo,
                                         input bit msg[$]);
    int n = msg.size();
    bit a[];
    logic [31:0] rem = '0;
    a = new[n + w];
    for (int i = 0; i < n + w; i++) a[i] = 1'b0;
    for (int i = 0; i < n; i++) a[i] = msg[i];
    for (int i = 0; i < w; i++) a[i] ^= seed[w-1-i];
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 1; j <= w; j++) a[i+j] ^= poly[w-j];
      end
    end
    for (int i = 0; i < w; i++) rem = {rem[30:0], 1'(a[n+i])};
    return rem ^ xo;
  endfunction

  // One complete frame on all engines with optional input gaps, output stalls and stray STARTs
  task automatic runFrame(input int n, input bit msg[$], input int gapPct, input int stallPct,
                          input int midStartAt, input bit startAtDone, input string tag);
    int idx = 0;
    int cyc = 0;
    int tail = 0;
    int lastAccept = -1;
    int limit = 8 * (n + 16) + 40;
    int firstValid [NDUT];
    int lastXfer [NDUT];
    int doneCyc [NDUT];
    int doneCnt [NDUT];
    int gotN [NDUT];
    logic [31:0] got [NDUT];
    logic [31:0] expCrc [NDUT];
    int expFirst;
    bit readyAfterEnd = 0;
    bit readyDisagree = 0;
    bit checkIdle = 0;
    bit allDone;
`ifdef CRC_PAR_OUT_EN
    int vldCnt [NDUT];
`endif
    for (int g = 0; g < NDUT; g++) begin
      firstValid[g] = -1; lastXfer[g] = -1; doneCyc[g] = -1; doneCnt[g] = 0;
      gotN[g] = 0; got[g] = '0;
      expCrc[g] = refCrc(int'(cfgWd[g]), cfgPoly[g], cfgSeed[g], cfgXor[g], msg);
`ifdef CRC_PAR_OUT_EN
      vldCnt[g] = 0;
`endif
    end

    @(negedge CLK);
    start = 1'b1;
    frameBits = 16'(n);
    @(negedge CLK);
    start = 1'b0;
    frameBits = 16'($urandom);

    while (tail < 3 && cyc < limit) begin
      start = 1'b0;
      if (checkIdle) begin
        checks++;
        if (busy[0] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s start_in_done_cycle: BUSY=%b expected 0", tag, busy[0]);
        end
        checkIdle = 0;
      end
      if (inReady[1] !== inReady[0] || inReady[2] !== inReady[0]) readyDisagree = 1;
      if (inReady[0] === 1'b1 && idx >= n) readyAfterEnd = 1;

      dataValid = ($urandom_range(99) >= gapPct);
      if (inReady[0] === 1'b1 && idx < n) data = msg[idx];
      else data = 1'($urandom);
      if (dataValid && inReady[0] === 1'b1 && idx < n) begin
        idx++;
        lastAccept = cyc;
      end
      if (cyc == midStartAt) begin
        start = 1'b1;
        frameBits = 16'($urandom);
      end

      outReady = ($urandom_range(99) >= stallPct);
      for (int g = 0; g < NDUT; g++) begin
        if (crcValid[g] === 1'b1) begin
          if (firstValid[g] < 0) firstValid[g] = cyc;
          if (outReady) begin
            got[g] = {got[g][30:0], crcOut[g]};
            gotN[g]++;
            lastXfer[g] = cyc;
          end
        end
        if (done[g] === 1'b1) begin
          doneCnt[g]++;
          doneCyc[g] = cyc;
        end
`ifdef CRC_PAR_OUT_EN
        if (crcWordVld[g] === 1'b1) vldCnt[g]++;
`endif
      end
      if (startAtDone && done[0] === 1'b1) begin
        start = 1'b1;
        frameBits = 16'($urandom);
        checkIdle = 1;
      end

      allDone = 1;
      for (int g = 0; g < NDUT; g++) if (doneCnt[g] == 0) allDone = 0;
      if (allDone) tail++;
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
    dataValid = 1'b0;
    outReady = 1'b0;

    checks++;
    if (cyc >= limit) begin
      failures++;
      $display("[TB] FAIL %s frame_timeout: ran %0d cycles, limit %0d", tag, cyc, limit);
    end
    checks++;
    if (idx != n || readyAfterEnd || readyDisagree) begin
      failures++;
      $display("[TB] FAIL %s input_handshake: accepted %0d bits expected %0d, extra_ready=%0d disagree=%0d",
               tag, idx, n, readyAfterEnd, readyDisagree);
    end
    expFirst = (n == 0) ? 0 : lastAccept + 1;
    for (int g = 0; g < NDUT; g++) begin
      lastCrc[g] = got[g];
      checks++;
      if (gotN[g] != int'(cfgWd[g]) || got[g] !== expCrc[g]) begin
        failures++;
        $display("[TB] FAIL %s crc dut%0d: got %h (%0d bits) expected %h (%0d bits)",
                 tag, g, got[g], gotN[g], expCrc[g], cfgWd[g]);
      end
      checks++;
      if (firstValid[g] != expFirst) begin
        failures++;
        $display("[TB] FAIL %s first_valid_cycle dut%0d: got %0d expected %0d", tag, g, firstValid[g], expFirst);
      end
      checks++;
      if (doneCnt[g] != 1 || doneCyc[g] != lastXfer[g] + 1) begin
        failures++;
        $display("[TB] FAIL %s done_pulse dut%0d: count %0d at cycle %0d, expected 1 at cycle %0d",
                 tag, g, doneCnt[g], doneCyc[g], lastXfer[g] + 1);
      end
`ifdef CRC_PAR_OUT_EN
      checks++;
      if (vldCnt[g] != 1 || crcWord[g] !== expCrc[g]) begin
        failures++;
        $display("[TB] FAIL %s crc_word dut%0d: word %h pulses %0d, expected %h with 1 pulse",
                 tag, g, crcWord[g], vldCnt[g], expCrc[g]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (inReady !== '0 || crcValid !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ready_valid: IN_READY=%b CRC_VALID=%b expected 0", inReady, crcValid);
    end
    checks++;
    if (crcOut !== '0 || busy !== '0 || done !== '0) begin
      failures++;
      $display("[TB] FAIL reset_out_busy_done: CRC_OUT=%b BUSY=%b DONE=%b expected 0", crcOut, busy, done);
    end
`ifdef CRC_PAR_OUT_EN
    checks++;
    if (crcWord !== '0 || crcWordVld !== '0) begin
      failures++;
      $display("[TB] FAIL reset_crc_word: CRC_WORD=%h VLD=%b expected 0", crcWord, crcWordVld);
    end
`endif
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_check_string();
    runFrame(72, checkString, 0, 0, -1, 0, "check_string");
    checks++;
    if (lastCrc[0] !== 32'hF4) begin
      failures++;
      $display("[TB] FAIL crc8_check_value: got %h expected f4", lastCrc[0]);
    end
    checks++;
    if (lastCrc[1] !== 32'h29B1) begin
      failures++;
      $display("[TB] FAIL crc16_check_value: got %h expected 29b1", lastCrc[1]);
    end
  endtask

  task automatic test_stalls();
    runFrame(72, checkString, 40, 40, -1, 0, "stalls");
    checks++;
    if (lastCrc[0] !== 32'hF4) begin
      failures++;
      $display("[TB] FAIL crc8_with_stalls: got %h expected f4", lastCrc[0]);
    end
  endtask

  task automatic test_zero_length();
    bit empty[$];
    runFrame(0, empty, 0, 30, -1, 0, "zero_length");
    checks++;
    if (lastCrc[2] !== 32'h5A) begin
      failures++;
      $display("[TB] FAIL zero_length_seed_xor: got %h expected 5a", lastCrc[2]);
    end
  endtask

  task automatic test_ignored_start();
    runFrame(72, checkString, 20, 20, 5, 1, "ignored_start");
    checks++;
    if (lastCrc[0] !== 32'hF4) begin
      failures++;
      $display("[TB] FAIL crc8_after_stray_start: got %h expected f4", lastCrc[0]);
    end
  endtask

  task automatic test_reset_abort();
    int guard = 0;
    bit activity = 0;
    @(negedge CLK);
    start = 1'b1;
    frameBits = 16'd16;
    @(negedge CLK);
    start = 1'b0;
    dataValid = 1'b1;
    outReady = 1'b1;
    while (crcValid[0] !== 1'b1 && guard < 100) begin
      data = 1'($urandom);
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      failures++;
      $display("[TB] FAIL abort_reach_shift_out: no CRC_VALID within %0d cycles", guard);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (inReady !== '0 || crcValid !== '0 || crcOut !== '0 || busy !== '0 || done !== '0) begin
      failures++;
      $display("[TB] FAIL async_abort_outputs: RDY=%b OUT=%b VLD=%b BUSY=%b DONE=%b expected all 0",
               inReady, crcOut, crcValid, busy, done);
    end
    dataValid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (crcValid !== '0 || busy !== '0 || done !== '0) activity = 1;
    end
    outReady = 1'b0;
    checks++;
    if (activity) begin
      failures++;
      $display("[TB] FAIL abort_no_partial_crc: activity=%0d expected 0 after reset release", activity);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      bit msg[$];
      int n = $urandom_range(1, 48);
      repeat (n) msg.push_back(1'($urandom));
      runFrame(n, msg, 30, 30, -1, 0, "random");
    end
  endtask

  initial begin
    for (int c = 8'h31; c <= 8'h39; c++)
      for (int b = 7; b >= 0; b--) checkString.push_back(1'((c >> b) & 1));
    test_reset();
    test_check_string();
    test_stalls();
    test_zero_length();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
